// File: rtl/bullet_hit_scanner_if.sv
// Collision-port bundle between the per-frame hit scanner and the Bullet table.
//
// The scanner (master) selects a slot with index2 and receives that slot's
// geometry, colour and live flag combinationally. It answers with isCollide,
// which clears the selected slot, and isRun, which advances all bullets.
//
// Signals:
//   index2     scanner -> Bullet   slot select for the collision read port
//   isCollide  scanner -> Bullet   clear-render strobe for slot index2
//   isRun      scanner -> Bullet   one-cycle bullet-advance pulse
//   position2  Bullet  -> scanner  [15:8] x, [7:0] y of slot index2
//   size2      Bullet  -> scanner  [15:8] w, [7:0] h of slot index2
//   color2     Bullet  -> scanner  00 white, 01 green, 10 blue, 11 reserved
//   isRender2  Bullet  -> scanner  slot index2 is live
interface bullet_hit_scanner_if #(
    parameter int IDX_W = 3
);
    logic [IDX_W-1:0] index2;
    logic             isCollide;
    logic             isRun;
    logic [15:0]      position2;
    logic [15:0]      size2;
    logic [1:0]       color2;
    logic             isRender2;

    modport master (
        output index2,
        output isCollide,
        output isRun,
        input  position2,
        input  size2,
        input  color2,
        input  isRender2
    );

    modport slave (
        input  index2,
        input  isCollide,
        input  isRun,
        output position2,
        output size2,
        output color2,
        output isRender2
    );
endinterface

// File: rtl/bullet_hit_scanner.sv
// Per-frame bullet hit scanner.
//
// On each accepted frame tick it walks every Bullet slot through the
// collision port, one slot per cycle, tests live bullets against the player
// box, applies damage or heal per hit, clears hit bullets, then issues a
// single isRun pulse to advance bullet motion.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for frame_tick; index2 holds its last value
// SCAN  | testing slot index2 this cycle (Mealy isCollide on a hit)
// MOVE  | isRun pulse; exits to DEAD if hp is 0, else IDLE
// DEAD  | hp exhausted; frames ignored until reset
//
// Ports:
//   clk, reset      system clock; synchronous active-high reset
//   frame_tick      one-cycle frame-start pulse
//   player_pos      [15:8] x, [7:0] y of the player box
//   player_size     [15:8] w, [7:0] h of the player box
//   player_moving   player moved this frame (enables blue bullets)
//   bullet          collision port to the Bullet table (master side)
//   hp              current player HP
//   dead            HP reached 0; sticky until reset
//   busy            scan or move in progress
//   hit_count       hits in the current/last frame, saturating at 255
//   overrun         sticky; frame_tick arrived while busy
module bullet_hit_scanner #(
    parameter int         NUM_SLOTS = 8,
    parameter int         IDX_W     = 3,
    parameter logic [7:0] HP_MAX    = 8'd20,
    parameter logic [7:0] DMG       = 8'd1,
    parameter logic [7:0] HEAL      = 8'd1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_tick,
    input  logic [15:0]           player_pos,
    input  logic [15:0]           player_size,
    input  logic                  player_moving,
    bullet_hit_scanner_if.master  bullet,
    output logic [7:0]            hp,
    output logic                  dead,
    output logic                  busy,
    output logic [7:0]            hit_count,
    output logic                  overrun
);

    localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(NUM_SLOTS - 1);

    localparam logic [1:0] COL_WHITE = 2'b00;
    localparam logic [1:0] COL_GREEN = 2'b01;
    localparam logic [1:0] COL_BLUE  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        MOVE = 2'd2,
        DEAD = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] slot_q;
    logic [7:0]       hp_q;
    logic [7:0]       cnt_q;
    logic             overrun_q;

    logic             overlap;
    logic             effective;
    logic             hit;
    logic             start_scan;
    logic [7:0]       hp_after_dmg;
    logic [7:0]       hp_after_heal;
    logic [8:0]       heal_sum;

    // Box edges are widened to 9 bits so a box near 255 extends past it
    // instead of wrapping back toward 0.
    logic [8:0] px, py, pw, ph, bx, by, bw, bh;

    assign px = {1'b0, player_pos[15:8]};
    assign py = {1'b0, player_pos[7:0]};
    assign pw = {1'b0, player_size[15:8]};
    assign ph = {1'b0, player_size[7:0]};
    assign bx = {1'b0, bullet.position2[15:8]};
    assign by = {1'b0, bullet.position2[7:0]};
    assign bw = {1'b0, bullet.size2[15:8]};
    assign bh = {1'b0, bullet.size2[7:0]};

    assign overlap = (bx < px + pw) && (px < bx + bw) &&
                     (by < py + ph) && (py < by + bh);

    always_comb begin
        effective = 1'b0;
        case (bullet.color2)
            COL_WHITE: effective = 1'b1;
            COL_GREEN: effective = 1'b1;
            COL_BLUE:  effective = player_moving;
            default:   effective = 1'b0;
        endcase
    end

    assign hp_after_dmg  = (hp_q > DMG) ? (hp_q - DMG) : 8'd0;
    assign heal_sum      = {1'b0, hp_q} + {1'b0, HEAL};
    assign hp_after_heal = (heal_sum > {1'b0, HP_MAX}) ? HP_MAX : heal_sum[7:0];

    // Next-state and Mealy outputs.
    always_comb begin
        state_d    = state_q;
        hit        = 1'b0;
        start_scan = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    state_d    = SCAN;
                    start_scan = 1'b1;
                end
            end
            SCAN: begin
                hit = bullet.isRender2 && overlap && effective;
                if (slot_q == LAST_SLOT) begin
                    state_d = MOVE;
                end
            end
            MOVE: begin
                // hp_q already includes the hit from the last slot.
                state_d = (hp_q == 8'd0) ? DEAD : IDLE;
            end
            DEAD: begin
                state_d = DEAD;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            slot_q    <= '0;
            hp_q      <= HP_MAX;
            cnt_q     <= 8'd0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;

            if (start_scan) begin
                slot_q <= '0;
                cnt_q  <= 8'd0;
            end else if (state_q == SCAN && slot_q != LAST_SLOT) begin
                slot_q <= slot_q + 1'b1;
            end

            if (hit) begin
                if (cnt_q != 8'hFF) begin
                    cnt_q <= cnt_q + 8'd1;
                end
                if (bullet.color2 == COL_GREEN) begin
                    hp_q <= hp_after_heal;
                end else begin
                    hp_q <= hp_after_dmg;
                end
            end

            // A tick in DEAD is not a collision with a running frame.
            if (frame_tick && (state_q == SCAN || state_q == MOVE)) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign bullet.index2    = slot_q;
    assign bullet.isCollide = hit;
    assign bullet.isRun     = (state_q == MOVE);

    assign hp        = hp_q;
    assign hit_count = cnt_q;
    assign overrun   = overrun_q;
    assign dead      = (state_q == DEAD);
    assign busy      = (state_q == SCAN) || (state_q == MOVE);

endmodule

// File: tb/tb_bullet_hit_scanner.sv
// Directed bench for bullet_hit_scanner. The bench plays the Bullet table
// and keeps a frame-level model: at each accepted tick it predicts which
// slots will hit from the box/colour rules, then walks that plan one slot
// per cycle while checking every DUT output every cycle.
module tb_bullet_hit_scanner;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        frame_tick;
    logic [15:0] player_pos;
    logic [15:0] player_size;
    logic        player_moving;
    logic [7:0]  hp;
    logic        dead;
    logic        busy;
    logic [7:0]  hit_count;
    logic        overrun;

    bullet_hit_scanner_if #(.IDX_W(3)) bif ();

    bullet_hit_scanner #(
        .NUM_SLOTS(8), .IDX_W(3), .HP_MAX(8'd20), .DMG(8'd1), .HEAL(8'd1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .player_pos   (player_pos),
        .player_size  (player_size),
        .player_moving(player_moving),
        .bullet       (bif),
        .hp           (hp),
        .dead         (dead),
        .busy         (busy),
        .hit_count    (hit_count),
        .overrun      (overrun)
    );

    // ---------------- Bullet table stand-in ----------------
    logic [7:0] b_x [8];
    logic [7:0] b_y [8];
    logic [7:0] b_w [8];
    logic [7:0] b_h [8];
    logic [1:0] b_c [8];
    logic [7:0] b_set;
    logic [7:0] b_clr;
    logic       clr_req;

    always_comb begin
        bif.position2 = {b_x[bif.index2], b_y[bif.index2]};
        bif.size2     = {b_w[bif.index2], b_h[bif.index2]};
        bif.color2    = b_c[bif.index2];
        bif.isRender2 = b_set[bif.index2] & ~b_clr[bif.index2];
    end

    always @(posedge clk) begin
        if (clr_req) b_clr <= '0;
        else if (bif.isCollide === 1'b1) b_clr[bif.index2] <= 1'b1;
    end

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- frame-level model ----------------
    int         ph;          // cycles since accepted tick, 0 when not in a frame
    int         m_hp, m_cnt, m_idx;
    bit         m_dead, m_ov;
    bit         plan_hit [8];
    logic [1:0] plan_col [8];
    int         n_run, n_col;

    task automatic model_reset();
        ph = 0; m_hp = 20; m_cnt = 0; m_idx = 0; m_dead = 0; m_ov = 0;
    endtask

    task automatic plan_frame();
        int px, py, pw, phh, bx, by, bw, bh;
        bit ov, eff, live;
        px = int'(player_pos[15:8]); py = int'(player_pos[7:0]);
        pw = int'(player_size[15:8]); phh = int'(player_size[7:0]);
        for (int i = 0; i < 8; i++) begin
            bx = int'(b_x[i]); by = int'(b_y[i]); bw = int'(b_w[i]); bh = int'(b_h[i]);
            live = b_set[i] && !b_clr[i];
            ov = (bx < px + pw) && (px < bx + bw) && (by < py + phh) && (py < by + bh);
            case (b_c[i])
                2'b00, 2'b01: eff = 1;
                2'b10:        eff = player_moving;
                default:      eff = 0;
            endcase
            plan_hit[i] = live && ov && eff;
            plan_col[i] = b_c[i];
        end
    endtask

    // One clock cycle: check outputs mid-cycle, advance the model with the
    // inputs held for this cycle, then return just after the next edge.
    task automatic step();
        bit exp_col;
        bit start;
        exp_col = 0;
        start   = 0;
        @(negedge clk);
        if (ph >= 1 && ph <= 8) begin
            m_idx   = ph - 1;
            exp_col = plan_hit[ph-1];
        end
        chk("busy",      busy,          (ph >= 1 && ph <= 9));
        chk("isRun",     bif.isRun,     (ph == 9));
        chk("isCollide", bif.isCollide, exp_col);
        chk("index2",    bif.index2,    m_idx);
        chk("hp",        hp,            m_hp);
        chk("hit_count", hit_count,     m_cnt);
        chk("dead",      dead,          m_dead);
        chk("overrun",   overrun,       m_ov);
        if (bif.isRun === 1'b1) n_run++;
        if (bif.isCollide === 1'b1) n_col++;

        if (reset) begin
            model_reset();
        end else begin
            if (exp_col) begin
                if (plan_col[ph-1] == 2'b01) m_hp = (m_hp + 1 > 20) ? 20 : m_hp + 1;
                else                         m_hp = (m_hp - 1 < 0) ? 0 : m_hp - 1;
                m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            end
            if (frame_tick) begin
                if (ph >= 1) m_ov = 1;
                else if (!m_dead) start = 1;
            end
            if (ph == 9) begin
                ph = 0;
                if (m_hp == 0) m_dead = 1;
            end else if (ph >= 1) begin
                ph++;
            end
            if (start) begin
                plan_frame();
                ph = 1;
                m_cnt = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic clear_table();
        for (int i = 0; i < 8; i++) begin
            b_x[i] = 8'd0; b_y[i] = 8'd0; b_w[i] = 8'd1; b_h[i] = 8'd1; b_c[i] = 2'b00;
        end
        b_set = '0;
    endtask

    task automatic put(int i, int x, int y, int w, int h, logic [1:0] c);
        b_x[i] = 8'(x); b_y[i] = 8'(y); b_w[i] = 8'(w); b_h[i] = 8'(h); b_c[i] = c;
        b_set[i] = 1'b1;
    endtask

    task automatic load();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
    endtask

    task automatic frame();
        n_run = 0; n_col = 0;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        repeat (10) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; frame_tick = 1'b0; player_moving = 1'b0; clr_req = 1'b1;
        player_pos = {8'd100, 8'd100}; player_size = {8'd16, 8'd16};
        clear_table();
        model_reset();
        n_run = 0; n_col = 0;
        @(posedge clk); #1;
        step(); step();
        reset = 1'b0; clr_req = 1'b0;
        step();

        // Non-overlapping live bullet only.
        clear_table(); put(0, 10, 10, 4, 4, 2'b00); load();
        frame();
        chk("t1_hp", hp, 20); chk("t1_cnt", hit_count, 0);
        chk("t1_runs", n_run, 1); chk("t1_cols", n_col, 0);

        // White hit in slot 2.
        clear_table(); put(2, 105, 105, 4, 4, 2'b00); load();
        frame();
        chk("t2_hp", hp, 19); chk("t2_cnt", hit_count, 1); chk("t2_clr", b_clr, 8'h04);

        // Blue in slot 5: still then moving.
        clear_table(); put(5, 104, 104, 8, 8, 2'b10); load();
        frame();
        chk("t3a_hp", hp, 19); chk("t3a_cols", n_col, 0); chk("t3a_clr", b_clr, 8'h00);
        player_moving = 1'b1;
        frame();
        chk("t3b_hp", hp, 18); chk("t3b_cols", n_col, 1);
        player_moving = 1'b0;

        // Drain HP to 1.
        clear_table();
        for (int i = 0; i < 8; i++) put(i, 100, 100, 16, 16, 2'b00);
        load(); frame();
        chk("t4a_hp", hp, 10); chk("t4a_cnt", hit_count, 8);
        load(); frame();
        chk("t4b_hp", hp, 2);
        clear_table(); put(0, 100, 100, 4, 4, 2'b00); load(); frame();
        chk("t4c_hp", hp, 1);

        // HP hits 0 then green restores it within one scan.
        put(4, 110, 110, 4, 4, 2'b01); load(); frame();
        chk("t4d_hp", hp, 1); chk("t4d_cnt", hit_count, 2); chk("t4d_dead", dead, 0);

        // Fatal frame, then ticks in DEAD.
        clear_table(); put(0, 100, 100, 4, 4, 2'b00); load(); frame();
        chk("t4e_hp", hp, 0); chk("t4e_dead", dead, 1);
        frame();
        chk("t4f_runs", n_run, 0); chk("t4f_ovr", overrun, 0); chk("t4f_dead", dead, 1);

        reset = 1'b1; step(); reset = 1'b0; step();
        chk("rst_hp", hp, 20); chk("rst_dead", dead, 0);

        // Green at HP_MAX plus a reserved-colour bullet.
        clear_table(); put(1, 101, 101, 4, 4, 2'b01); put(3, 102, 102, 4, 4, 2'b11); load();
        frame();
        chk("t5_hp", hp, 20); chk("t5_cnt", hit_count, 1); chk("t5_clr", b_clr, 8'h02);

        // Edge overlap.
        clear_table(); put(0, 116, 105, 4, 4, 2'b00); load(); frame();
        chk("t6a_cnt", hit_count, 0);
        clear_table(); put(0, 115, 105, 4, 4, 2'b00); load(); frame();
        chk("t6b_cnt", hit_count, 1); chk("t6b_hp", hp, 19);
        player_pos = {8'd250, 8'd100}; player_size = {8'd10, 8'd16};
        clear_table(); put(0, 255, 105, 4, 4, 2'b00); load(); frame();
        chk("t6c_cnt", hit_count, 1); chk("t6c_hp", hp, 18);
        player_pos = {8'd100, 8'd100}; player_size = {8'd16, 8'd16};

        // Tick during scan.
        clear_table(); load();
        n_run = 0;
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        repeat (3) step();
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        repeat (6) step();
        chk("t7_ovr", overrun, 1); chk("t7_runs", n_run, 1);

        // Reset mid-scan after a hit.
        clear_table(); put(0, 100, 100, 4, 4, 2'b00); load();
        n_run = 0;
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        repeat (4) step();
        reset = 1'b1; step(); reset = 1'b0;
        chk("t8_hp", hp, 20); chk("t8_ovr", overrun, 0); chk("t8_busy", busy, 0);
        chk("t8_idx", bif.index2, 0); chk("t8_cnt", hit_count, 0);
        repeat (6) step();
        chk("t8_runs", n_run, 0); chk("t8_clr", b_clr, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
